// File: rtl/cdb_pkg.sv
// Shared types for CDB-attached units: result entry payload, bus tag constants
// and the result-queue state encoding.
package cdb_pkg;

    localparam int unsigned CDB_ARN_W  = 5;
    localparam int unsigned CDB_RRN_W  = 6;
    localparam int unsigned CDB_DATA_W = 32;
    localparam int unsigned CDB_TAG_W  = 4;

    localparam logic [CDB_TAG_W-1:0] CDB_TAG_NONE = 4'h0;

    typedef struct packed {
        logic [CDB_ARN_W-1:0]  arn;
        logic [CDB_RRN_W-1:0]  rrn;
        logic [CDB_DATA_W-1:0] data;
    } cdb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BCAST = 2'd2
    } cdb_q_state_t;

endpackage

// File: rtl/result_fifo.sv
// Result storage FIFO for the CDB result queue: DEPTH entries (power of two),
// pointers wrap naturally, count has one extra bit to distinguish full.
module result_fifo
    import cdb_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  cdb_entry_t       i_push_entry,
    input  logic             i_pop,
    output cdb_entry_t       o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    cdb_entry_t       r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full && !i_clear;
    assign w_do_pop  = i_pop && !w_empty && !i_clear;

    // Pointer and occupancy tracking; clear empties the queue in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Entry storage; contents are only meaningful under the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/cdb_result_queue.sv
// Output stage of an execution unit feeding the CDB arbiter. Queues completed
// results, requests the bus while non-empty and broadcasts the head entry for
// one cycle per grant, tagged with the low nibble of ADDRESS.
// Optional: define CDB_QUEUE_FLUSH_EN to add a synchronous 'flush' input that
// empties the queue and returns the controller to IDLE.
module cdb_result_queue
    import cdb_pkg::*;
#(
    parameter  logic [7:0]  ADDRESS   = 8'h00,
    parameter  int unsigned CDB_COUNT = 2,
    parameter  int unsigned DEPTH     = 4,
    parameter  int unsigned DATA_W    = 32,
    localparam int unsigned SEL_W     = (CDB_COUNT > 1) ? $clog2(CDB_COUNT) : 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef CDB_QUEUE_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CDB_ARN_W-1:0] in_arn,
    input  logic [CDB_RRN_W-1:0] in_rrn,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 get_bus,
    input  logic                 bus_granted,
    input  logic [SEL_W-1:0]     bus_selected,
    output logic                 out_valid,
    output logic [SEL_W-1:0]     out_bus,
    output logic [CDB_TAG_W-1:0] out_tag,
    output logic [CDB_ARN_W-1:0] out_arn,
    output logic [CDB_RRN_W-1:0] out_rrn,
    output logic [DATA_W-1:0]    out_data
);

    cdb_q_state_t r_state;
    cdb_q_state_t w_state_next;

    logic                 w_flush;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    cdb_entry_t           w_push_entry;
    cdb_entry_t           w_head;

    logic                 r_out_valid;
    logic [SEL_W-1:0]     r_out_bus;
    logic [CDB_TAG_W-1:0] r_out_tag;
    logic [CDB_ARN_W-1:0] r_out_arn;
    logic [CDB_RRN_W-1:0] r_out_rrn;
    logic [DATA_W-1:0]    r_out_data;

`ifdef CDB_QUEUE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // in_ready comes straight from the registered count: a pop never frees a slot
    // for a push at the same edge.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full && !w_flush;
    assign w_pop    = (r_state == REQ) && bus_granted && !w_flush;
    assign get_bus  = (r_state == REQ);

    // The package payload carries up to CDB_DATA_W bits of result data.
    assign w_push_entry = '{arn: in_arn, rrn: in_rrn, data: CDB_DATA_W'(in_data)};

    result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_flush),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; w_empty already reflects any pop taken on entry to BCAST.
    always_comb begin
        w_state_next = r_state;
        if (w_flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (!w_empty || w_push) w_state_next = REQ;
                REQ:     if (bus_granted) w_state_next = BCAST;
                BCAST:   w_state_next = (!w_empty || w_push) ? REQ : IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Broadcast registers: loaded on a granted pop, zero in every other cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_bus   <= '0;
            r_out_tag   <= CDB_TAG_NONE;
            r_out_arn   <= '0;
            r_out_rrn   <= '0;
            r_out_data  <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_bus   <= bus_selected;
            r_out_tag   <= ADDRESS[CDB_TAG_W-1:0];
            r_out_arn   <= w_head.arn;
            r_out_rrn   <= w_head.rrn;
            r_out_data  <= DATA_W'(w_head.data);
        end else begin
            r_out_valid <= 1'b0;
            r_out_bus   <= '0;
            r_out_tag   <= CDB_TAG_NONE;
            r_out_arn   <= '0;
            r_out_rrn   <= '0;
            r_out_data  <= '0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_bus   = r_out_bus;
    assign out_tag   = r_out_tag;
    assign out_arn   = r_out_arn;
    assign out_rrn   = r_out_rrn;
    assign out_data  = r_out_data;

    // Occupancy is tracked inside the FIFO; only full/empty are needed here.
    logic w_count_unused;
    assign w_count_unused = ^w_count;

endmodule

// File: tb/tb_cdb_result_queue.sv
// Directed self-checking bench for cdb_result_queue (ADDRESS=8'hA5, 2 CDBs, depth 4).
module tb_cdb_result_queue;

    logic        clk = 1'b0;
    logic        reset;
`ifdef CDB_QUEUE_FLUSH_EN
    logic        flush;
`endif
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_arn;
    logic [5:0]  in_rrn;
    logic [31:0] in_data;
    logic        get_bus;
    logic        bus_granted;
    logic [0:0]  bus_selected;
    logic        out_valid;
    logic [0:0]  out_bus;
    logic [3:0]  out_tag;
    logic [4:0]  out_arn;
    logic [5:0]  out_rrn;
    logic [31:0] out_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cdb_result_queue #(
        .ADDRESS   (8'hA5),
        .CDB_COUNT (2),
        .DEPTH     (4),
        .DATA_W    (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef CDB_QUEUE_FLUSH_EN
        .flush        (flush),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_arn       (in_arn),
        .in_rrn       (in_rrn),
        .in_data      (in_data),
        .get_bus      (get_bus),
        .bus_granted  (bus_granted),
        .bus_selected (bus_selected),
        .out_valid    (out_valid),
        .out_bus      (out_bus),
        .out_tag      (out_tag),
        .out_arn      (out_arn),
        .out_rrn      (out_rrn),
        .out_data     (out_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_now(input logic [4:0] arn, input logic [5:0] rrn, input logic [31:0] data);
        in_valid = 1'b1; in_arn = arn; in_rrn = rrn; in_data = data;
        tick();
        in_valid = 1'b0; in_arn = '0; in_rrn = '0; in_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_arn = '0; in_rrn = '0; in_data = '0;
        bus_granted = 1'b0; bus_selected = 1'b0;
`ifdef CDB_QUEUE_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        tests++; if (get_bus !== 1'b0)    begin fails++; $display("FAIL reset_get_bus: got %b exp 0", get_bus); end
        tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        tests++; if (out_tag !== 4'h0)    begin fails++; $display("FAIL reset_out_tag: got %h exp 0", out_tag); end
        tests++; if (out_data !== 32'h0)  begin fails++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
        tests++; if (out_bus !== 1'b0)    begin fails++; $display("FAIL reset_out_bus: got %b exp 0", out_bus); end
        reset = 1'b0;
        tick();
        tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        tests++; if (get_bus !== 1'b0)    begin fails++; $display("FAIL reset_idle_get_bus: got %b exp 0", get_bus); end
    endtask

    task automatic test_single();
        bus_granted = 1'b1; bus_selected = 1'b1;
        push_now(5'd3, 6'd17, 32'hDEADBEEF);
        tests++; if (get_bus !== 1'b1)   begin fails++; $display("FAIL single_req: got %b exp 1", get_bus); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b exp 0", out_valid); end
        tick();
        tests++; if (out_valid !== 1'b1)        begin fails++; $display("FAIL single_valid: got %b exp 1", out_valid); end
        tests++; if (out_bus !== 1'b1)          begin fails++; $display("FAIL single_bus: got %b exp 1", out_bus); end
        tests++; if (out_tag !== 4'h5)          begin fails++; $display("FAIL single_tag: got %h exp 5", out_tag); end
        tests++; if (out_arn !== 5'd3)          begin fails++; $display("FAIL single_arn: got %0d exp 3", out_arn); end
        tests++; if (out_rrn !== 6'd17)         begin fails++; $display("FAIL single_rrn: got %0d exp 17", out_rrn); end
        tests++; if (out_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data: got %h exp deadbeef", out_data); end
        tests++; if (get_bus !== 1'b0)          begin fails++; $display("FAIL single_bcast_get_bus: got %b exp 0", get_bus); end
        tick();
        tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL single_clear_valid: got %b exp 0", out_valid); end
        tests++; if (out_tag !== 4'h0)    begin fails++; $display("FAIL single_clear_tag: got %h exp 0", out_tag); end
        tests++; if (out_data !== 32'h0)  begin fails++; $display("FAIL single_clear_data: got %h exp 0", out_data); end
        tests++; if (get_bus !== 1'b0)    begin fails++; $display("FAIL single_idle_get_bus: got %b exp 0", get_bus); end
        tick();
        tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL single_no_repeat: got %b exp 0", out_valid); end
        bus_granted = 1'b0; bus_selected = 1'b0;
    endtask

    task automatic test_full();
        bus_granted = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_before_%0d: got %b exp 1", i, in_ready); end
            push_now(5'(i), 6'(10 + i), 32'(i));
        end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b exp 0", in_ready); end
        tests++; if (get_bus !== 1'b1)  begin fails++; $display("FAIL full_get_bus: got %b exp 1", get_bus); end
        // Offer a 5th entry while full, held through the first granted pop.
        in_valid = 1'b1; in_arn = 5'd5; in_rrn = 6'd15; in_data = 32'd5;
        tick();
        tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL full_ready_hold: got %b exp 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_no_grant_valid: got %b exp 0", out_valid); end
        bus_granted = 1'b1;
        tick();
        in_valid = 1'b0; in_arn = '0; in_rrn = '0; in_data = '0;
        tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL full_bcast1_valid: got %b exp 1", out_valid); end
        tests++; if (out_data !== 32'd1)  begin fails++; $display("FAIL full_bcast1_data: got %0d exp 1", out_data); end
        tests++; if (out_rrn !== 6'd11)   begin fails++; $display("FAIL full_bcast1_rrn: got %0d exp 11", out_rrn); end
        tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL full_ready_after_pop: got %b exp 1", in_ready); end
        for (int k = 2; k <= 4; k++) begin
            tick();
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_gap%0d_valid: got %b exp 0", k, out_valid); end
            tests++; if (get_bus !== 1'b1)   begin fails++; $display("FAIL full_gap%0d_req: got %b exp 1", k, get_bus); end
            tick();
            tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL full_bcast%0d_valid: got %b exp 1", k, out_valid); end
            tests++; if (out_data !== 32'(k)) begin fails++; $display("FAIL full_bcast%0d_data: got %0d exp %0d", k, out_data, k); end
            tests++; if (out_arn !== 5'(k))   begin fails++; $display("FAIL full_bcast%0d_arn: got %0d exp %0d", k, out_arn, k); end
        end
        tick();
        tests++; if (get_bus !== 1'b0) begin fails++; $display("FAIL full_drained_get_bus: got %b exp 0", get_bus); end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_no_fifth_%0d: got %b exp 0 data %0d", k, out_valid, out_data); end
        end
        bus_granted = 1'b0;
    endtask

    task automatic test_push_pop();
        bus_granted = 1'b0;
        push_now(5'd1, 6'd1, 32'hA1);
        push_now(5'd2, 6'd2, 32'hB2);
        in_valid = 1'b1; in_arn = 5'd3; in_rrn = 6'd3; in_data = 32'hC3;
        bus_granted = 1'b1;
        tick();
        in_valid = 1'b0; in_arn = '0; in_rrn = '0; in_data = '0;
        tests++; if (out_data !== 32'hA1) begin fails++; $display("FAIL pp_first: got %h exp a1", out_data); end
        tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL pp_ready: got %b exp 1", in_ready); end
        tick();
        tests++; if (get_bus !== 1'b1)    begin fails++; $display("FAIL pp_req2: got %b exp 1", get_bus); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_data !== 32'hB2) begin fails++; $display("FAIL pp_second: got v=%b %h exp v=1 b2", out_valid, out_data); end
        tick();
        tests++; if (get_bus !== 1'b1)    begin fails++; $display("FAIL pp_req3: got %b exp 1", get_bus); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_data !== 32'hC3) begin fails++; $display("FAIL pp_third: got v=%b %h exp v=1 c3", out_valid, out_data); end
        tick();
        tests++; if (get_bus !== 1'b0)    begin fails++; $display("FAIL pp_empty_req: got %b exp 0", get_bus); end
        tick();
        tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL pp_no_extra: got %b exp 0", out_valid); end
        bus_granted = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] vld_pat;
        logic [31:0] gnt_pat;
        logic [31:0] q[$];
        logic [31:0] exp_d;
        logic        exp_pop;
        logic        exp_sel;
        logic        push_ok;
        int          tx;
        int          rx;
        vld_pat = 32'b1101_1011_1110_0111_0101_1111_0110_1011;
        gnt_pat = 32'b0110_1001_1100_0101_1011_0010_0111_0100;
        tx = 0; rx = 0;
        for (int cyc = 0; cyc < 300 && rx < 10; cyc++) begin
            in_valid     = (tx < 10) && vld_pat[cyc % 32];
            in_data      = 32'h100 + 32'(tx);
            in_arn       = 5'(tx);
            in_rrn       = 6'(tx + 20);
            bus_granted  = gnt_pat[cyc % 32];
            bus_selected = 1'(cyc);
            exp_pop      = get_bus && bus_granted;
            exp_sel      = bus_selected;
            push_ok      = in_valid && in_ready;
            tick();
            if (push_ok) begin q.push_back(32'h100 + 32'(tx)); tx++; end
            tests++; if (out_valid !== exp_pop) begin fails++; $display("FAIL wrap_valid_c%0d: got %b exp %b", cyc, out_valid, exp_pop); end
            if (exp_pop) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
                tests++; if (out_data !== exp_d)  begin fails++; $display("FAIL wrap_data_%0d: got %h exp %h", rx, out_data, exp_d); end
                tests++; if (out_bus !== exp_sel) begin fails++; $display("FAIL wrap_bus_%0d: got %b exp %b", rx, out_bus, exp_sel); end
                rx++;
            end
        end
        in_valid = 1'b0; bus_granted = 1'b0; bus_selected = 1'b0; in_data = '0; in_arn = '0; in_rrn = '0;
        tests++; if (rx != 10) begin fails++; $display("FAIL wrap_timeout: got %0d broadcasts exp 10", rx); end
        tick();
        tests++; if (get_bus !== 1'b0)  begin fails++; $display("FAIL wrap_final_get_bus: got %b exp 0", get_bus); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL wrap_final_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_reset_bcast();
        bus_granted = 1'b0;
        push_now(5'd7, 6'd7, 32'h11);
        push_now(5'd8, 6'd8, 32'h22);
        bus_granted = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin fails++; $display("FAIL rb_bcast: got v=%b %h exp v=1 11", out_valid, out_data); end
        #1;
        reset = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rb_async_valid: got %b exp 0", out_valid); end
        tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL rb_async_data: got %h exp 0", out_data); end
        tests++; if (out_tag !== 4'h0)   begin fails++; $display("FAIL rb_async_tag: got %h exp 0", out_tag); end
        tests++; if (get_bus !== 1'b0)   begin fails++; $display("FAIL rb_async_get_bus: got %b exp 0", get_bus); end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rb_stale_valid_%0d: got %b exp 0", k, out_valid); end
            tests++; if (get_bus !== 1'b0)   begin fails++; $display("FAIL rb_stale_req_%0d: got %b exp 0", k, get_bus); end
            tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL rb_ready_%0d: got %b exp 1", k, in_ready); end
        end
        bus_granted = 1'b0;
    endtask

`ifdef CDB_QUEUE_FLUSH_EN
    task automatic test_flush();
        bus_granted = 1'b0;
        push_now(5'd1, 6'd1, 32'h31);
        push_now(5'd2, 6'd2, 32'h32);
        push_now(5'd3, 6'd3, 32'h33);
        tests++; if (get_bus !== 1'b1) begin fails++; $display("FAIL flush_pre_req: got %b exp 1", get_bus); end
        flush = 1'b1;
        in_valid = 1'b1; in_data = 32'h77;
        tick();
        flush = 1'b0; in_valid = 1'b0; in_data = '0;
        tests++; if (get_bus !== 1'b0)  begin fails++; $display("FAIL flush_get_bus: got %b exp 0", get_bus); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b exp 1", in_ready); end
        bus_granted = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_bcast_%0d: got %b exp 0", k, out_valid); end
        end
        bus_granted = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full();
        test_push_pop();
        test_wrap();
        test_reset_bcast();
`ifdef CDB_QUEUE_FLUSH_EN
        test_flush();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/cdb_result_queue.md
Name: cdb_result_queue

Overview:
- Output stage of an execution unit, directly upstream of the CDB arbiter.
- Buffers completed results in a small FIFO and raises get_bus while it holds data.
- On bus_granted, broadcasts the head entry onto the CDB index given by bus_selected, tagged with its device address.
- One instance per CDB-attached unit; the arbiter instance shares its ADDRESS.

Parameters:
- ADDRESS, 8'h00: device address; low 4 bits are driven as the bus tag; 0 is reserved for "disconnected".
- CDB_COUNT, 2: number of common data buses; bus_selected/out_bus width = $clog2(CDB_COUNT) (min 1).
- DEPTH, 4: FIFO entries; power of two, >= 2.
- DATA_W, 32: result data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  result offered by the execution unit.
- in_ready  out  1  queue can accept; equals !full (registered count, no bypass).
- in_arn  in  5  architectural destination register.
- in_rrn  in  6  rename destination register.
- in_data  in  DATA_W  result value.
- get_bus  out  1  bus request to the arbiter.
- bus_granted  in  1  grant from the arbiter (combinational in the same cycle).
- bus_selected  in  $clog2(CDB_COUNT)  CDB index granted.
- out_valid  out  1  broadcast strobe, one cycle per entry.
- out_bus  out  $clog2(CDB_COUNT)  CDB index being driven.
- out_tag  out  4  ADDRESS[3:0] while out_valid, else 0.
- out_arn / out_rrn / out_data  out  5 / 6 / DATA_W  head entry fields; 0 when !out_valid.

Behaviour:
- Reset (async): count=0, rd/wr pointers=0, state=IDLE. get_bus=0, out_valid=0, out_bus=0, out_tag=0, all out fields=0. in_ready=1 from the first cycle after reset deassertion.
- Push: when in_valid && in_ready at an edge, write the entry at wr_ptr, wr_ptr++ (wraps mod DEPTH), count++.
- FSM IDLE:
  - Moves to REQ at the edge where count becomes nonzero.
  - get_bus=0.
- FSM REQ:
  - get_bus=1, driven combinationally from state.
  - If bus_granted is sampled high at an edge: register head entry and bus_selected into the outputs, set out_valid=1, pop (rd_ptr++, count--), go to BCAST.
  - Otherwise stay in REQ.
- FSM BCAST:
  - out_valid=1 for exactly this cycle; get_bus=0.
  - Next edge: out_valid and out fields clear to 0.
  - Go to REQ if count>0 (including an entry pushed this cycle), else IDLE.
- Latency:
  - Push at edge t -> get_bus high in cycle t+1.
  - Grant in cycle t+1 -> out_valid in cycle t+2.
  - Max throughput is one broadcast per 2 cycles.
- Simultaneous push and pop at the same edge: count unchanged, both pointers advance.
- Full:
  - in_ready=0; in_valid is ignored and the entry is not written.
  - A pop at the same edge does not make room in that same cycle; in_ready rises the following cycle.
- Empty: never requests the bus. A grant received outside REQ is ignored; no pop.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits.
- Reset mid-broadcast: outputs clear immediately (async); the queue is emptied.

Optional Feature:
- Macro: CDB_QUEUE_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - flush high at an edge: count=0, pointers=0, state=IDLE, out_valid=0.
  - A push in the same cycle is dropped.
  - get_bus drops in the cycle after the flush edge.
- Undefined: no flush port; the queue is cleared by reset only.

Decomposition:
- Shared package cdb_pkg:
  - cdb_entry_t struct {arn, rrn, data}.
  - Constants CDB_TAG_W=4 and CDB_TAG_NONE=4'h0.
  - Queue state enum {IDLE, REQ, BCAST}.
- Sub-module result_fifo: parameterised storage of cdb_entry_t, with push/pop/count/full/empty. The FSM and bus interface stay in the top.

Test Plan:
- Push 1 entry (arn=3, rrn=17, data=32'hDEADBEEF) with bus_granted tied 1, bus_selected=1 -> get_bus in cycle t+1; out_valid, out_bus=1, out_tag=ADDRESS[3:0], out_data=32'hDEADBEEF in t+2 only; then IDLE.
- Push 4 entries, grant withheld -> in_ready=0 after the 4th; a 5th push with data=5 is dropped; on grants, outputs show entries 1..4 in order on alternate cycles; no 5th broadcast.
- Fill/drain 10 entries with random grants -> FIFO order preserved across pointer wrap; count returns to 0, get_bus=0.
- Push and grant-pop at the same edge with count=2 -> count stays 2; data order intact.
- Assert reset during BCAST -> out_valid=0 and get_bus=0 asynchronously; in_ready=1 after release; no stale broadcast.
- With CDB_QUEUE_FLUSH_EN, 3 entries queued, flush=1 -> get_bus=0 the next cycle; subsequent grants produce no out_valid.
